// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state codes,
// the PC register reset value and a word-alignment helper.
package ifetch_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_IDLE = 2'd0;
    localparam fsm_state_t S_REQ  = 2'd1;
    localparam fsm_state_t S_WAIT = 2'd2;
    localparam fsm_state_t S_HOLD = 2'd3;

    // Must match the reset value of the external PC register.
    localparam logic [31:0] PC_RESET = 32'h0;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/inst_hold_reg.sv
// Enabled holding register for the fetched instruction and its PC, with a
// synchronous active-low clear.
module inst_hold_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: reads imem at pc_in, hands the instruction to
// decode and loads the PC register with PC+step or a redirect target.
// Optional misaligned-PC fault output enabled by IFETCH_ALIGN_CHECK_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int PC_STEP = 4,
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_ena,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic              fetch_fault,
`endif
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fsm_state_t                state;
    fsm_state_t                state_nxt;
    logic                      drop;
    logic                      redir_pend;
    logic [ADDR_W-1:0]         redir_pend_target;
    logic                      pc_busy;
    logic                      fetch_block;
    logic                      req_ok;
    logic                      req_fire;
    logic                      rsp_take;
    logic [INST_W+ADDR_W-1:0]  hold_q;

    // pc_in is stale while a load is in flight or a redirect load is still queued.
    assign pc_busy  = pc_ena || redir_pend;
    assign req_ok   = (state == S_REQ) && !pc_busy && !redirect_valid && !fetch_block;
    assign req_fire = req_ok && imem_req_ready;
    assign rsp_take = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (req_fire) state_nxt = S_WAIT;
            S_WAIT: if (imem_rsp_valid) state_nxt = (drop || redirect_valid) ? S_REQ : S_HOLD;
            S_HOLD: if (redirect_valid || inst_ready) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_addr      = '0;
        inst_valid     = 1'b0;
        case (state)
            S_REQ: begin
                imem_req_valid = req_ok;
                if (req_ok) imem_addr = pc_in;
            end
            S_HOLD:  inst_valid = 1'b1;
            default: ;
        endcase
    end

    // A redirect that lands while pc_ena is already high is queued one cycle,
    // keeping pc_ena a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_ena     <= 1'b0;
            pc_next    <= ADDR_W'(PC_RESET);
            redir_pend <= 1'b0;
        end else if (pc_ena) begin
            pc_ena <= 1'b0;
            if (redirect_valid) redir_pend <= 1'b1;
        end else if (redirect_valid) begin
            pc_ena     <= 1'b1;
            pc_next    <= redirect_target;
            redir_pend <= 1'b0;
        end else if (redir_pend) begin
            pc_ena     <= 1'b1;
            pc_next    <= redir_pend_target;
            redir_pend <= 1'b0;
        end else if (rsp_take) begin
            pc_ena  <= 1'b1;
            pc_next <= pc_in + STEP;
        end
    end

    // NOTE: data-only storage qualified by redir_pend carries no reset.
    always_ff @(posedge clk) begin
        if (pc_ena && redirect_valid) begin
            redir_pend_target <= redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop <= 1'b0;
        end else if (state != S_WAIT || imem_rsp_valid) begin
            drop <= 1'b0;
        end else if (redirect_valid) begin
            drop <= 1'b1;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    assign fetch_block = fetch_fault || !is_word_aligned(pc_in[1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            if (is_word_aligned(redirect_target[1:0])) fetch_fault <= 1'b0;
        end else if (state == S_REQ && !pc_busy && !is_word_aligned(pc_in[1:0])) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign fetch_block = 1'b0;
`endif

    inst_hold_reg #(
        .W(INST_W + ADDR_W)
    ) u_hold (
        .clk(clk),
        .rst(rst),
        .ena(rsp_take),
        .d  ({imem_rsp_data, pc_in}),
        .q  (hold_q)
    );

    assign {inst_data, inst_pc} = hold_q;

endmodule
